// File: rtl/dark_channel_source.sv
// Dark-channel pixel source: reads a frame of {R,G,B} words, emits min(R,G,B) per pixel in raster
// order, then appends all-ones flush pixels, all through a 2-entry ready/valid output buffer.
module dark_channel_source #(
   parameter int WIDTH      = 160,
   parameter int HEIGHT     = 120,
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 15,
   parameter int FLUSH_LEN  = WIDTH + 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   output logic                    mem_rd_en,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   input  logic [3*DATA_WIDTH-1:0] mem_rd_data,
   output logic [DATA_WIDTH-1:0]   out_val,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_last
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WIDTH * HEIGHT - 1);
   localparam int                    FCW        = $clog2(FLUSH_LEN + 1);
   localparam logic [FCW-1:0]        LAST_FLUSH = FCW'(FLUSH_LEN - 1);

   typedef enum logic [1:0] {IDLE, FRAME, FLUSH, DRAIN} state_t;

   state_t                state;
   logic [FCW-1:0]        flush_cnt;
   logic [DATA_WIDTH-1:0] fifo_val  [2];
   logic                  fifo_last [2];
   logic                  rd_ptr;
   logic                  wr_ptr;
   logic [1:0]            occ;
   logic [1:0]            next_occ;
   logic                  pend;
   logic                  pend_flush;
   logic                  pend_last;
   logic                  pop;
   logic                  issue;
   logic [2:0]            load;
   logic [DATA_WIDTH-1:0] ch_r;
   logic [DATA_WIDTH-1:0] ch_g;
   logic [DATA_WIDTH-1:0] ch_b;
   logic [DATA_WIDTH-1:0] pix_min;

   assign out_valid = (occ != 2'd0);
   assign out_val   = fifo_val[rd_ptr];
   assign out_last  = out_valid && fifo_last[rd_ptr];
   assign pop       = out_valid && out_ready;

   // Frame reads and flush tokens share one issue slot and one-cycle return stage, so flush
   // pixels queue behind the last frame read. Credit counts occupancy after this cycle's pop.
   always_comb begin
      load      = 3'(occ) + 3'(pend) - 3'(pop);
      issue     = !rst && (state == FRAME || state == FLUSH) && (load < 3'd2);
      mem_rd_en = issue && (state == FRAME);
      next_occ  = occ + 2'(pend) - 2'(pop);
   end

   always_comb begin
      ch_r    = mem_rd_data[3*DATA_WIDTH-1 -: DATA_WIDTH];
      ch_g    = mem_rd_data[2*DATA_WIDTH-1 -: DATA_WIDTH];
      ch_b    = mem_rd_data[DATA_WIDTH-1:0];
      pix_min = ch_r;
      if (ch_g < pix_min) pix_min = ch_g;
      if (ch_b < pix_min) pix_min = ch_b;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         occ        <= 2'd0;
         rd_ptr     <= 1'b0;
         wr_ptr     <= 1'b0;
         pend       <= 1'b0;
         pend_flush <= 1'b0;
         pend_last  <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            fifo_val[i]  <= '0;
            fifo_last[i] <= 1'b0;
         end
      end else begin
         pend       <= issue;
         pend_flush <= (state == FLUSH);
         pend_last  <= (state == FLUSH) && (flush_cnt == LAST_FLUSH);
         if (pend) begin
            fifo_val[wr_ptr]  <= pend_flush ? '1 : pix_min;
            fifo_last[wr_ptr] <= pend_last;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         occ <= next_occ;
      end
   end

   // The done cycle is already IDLE, so start is masked by done to stop back-to-back restarts.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         mem_addr  <= '0;
         flush_cnt <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !done) begin
                  state    <= FRAME;
                  mem_addr <= '0;
                  busy     <= 1'b1;
               end
            end
            FRAME: begin
               if (issue) begin
                  if (mem_addr == LAST_ADDR) begin
                     state     <= FLUSH;
                     flush_cnt <= '0;
                  end else begin
                     mem_addr <= mem_addr + ADDR_WIDTH'(1);
                  end
               end
            end
            FLUSH: begin
               if (issue) begin
                  if (flush_cnt == LAST_FLUSH) state <= DRAIN;
                  else flush_cnt <= flush_cnt + FCW'(1);
               end
            end
            DRAIN: begin
               if (next_occ == 2'd0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dark_channel_source.sv
// Scoreboard bench for dark_channel_source: a small 4x3 instance for directed frames and a
// default-parameter instance for the full-size transfer count.
module tb_dark_channel_source;

   localparam int W     = 4;
   localparam int H     = 3;
   localparam int FL    = 5;
   localparam int AW    = 4;
   localparam int NPIX  = W * H;
   localparam int NXFER = NPIX + FL;
   localparam int NPIX2 = 160 * 120;
   localparam int NXF2  = NPIX2 + 161;

   typedef struct packed {
      logic       last;
      logic [7:0] val;
   } exp_t;

   logic          clk;
   logic          rst;
   logic          start;
   logic          busy;
   logic          done;
   logic          mem_rd_en;
   logic [AW-1:0] mem_addr;
   logic [23:0]   mem_rd_data;
   logic [7:0]    out_val;
   logic          out_valid;
   logic          out_ready;
   logic          out_last;

   logic          start2;
   logic          busy2;
   logic          done2;
   logic          mem_rd_en2;
   logic [14:0]   mem_addr2;
   logic [23:0]   mem_rd_data2;
   logic [7:0]    out_val2;
   logic          out_valid2;
   logic          out_last2;

   logic [23:0] mem    [16];
   logic [23:0] mix_w  [NPIX];
   logic [7:0]  mix_e  [NPIX];
   exp_t        exp_q  [$];
   exp_t        mon_e;

   int n_compared   = 0;
   int n_mismatched = 0;
   int xfer_cnt     = 0;
   int rd_cnt       = 0;
   int exp_addr     = 0;
   int xfers2       = 0;
   int bad2         = 0;
   int busy_low2    = 0;
   int done_cnt2    = 0;
   bit mon_en       = 0;
   bit rand_ready   = 0;
   bit stall_prev   = 0;
   bit last_prev    = 0;
   bit active2      = 0;

   dark_channel_source #(
      .WIDTH(W), .HEIGHT(H), .DATA_WIDTH(8), .ADDR_WIDTH(AW), .FLUSH_LEN(FL)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
      .out_val(out_val), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
   );

   dark_channel_source dut2 (
      .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
      .mem_rd_en(mem_rd_en2), .mem_addr(mem_addr2), .mem_rd_data(mem_rd_data2),
      .out_val(out_val2), .out_valid(out_valid2), .out_ready(1'b1), .out_last(out_last2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Frame memories: one-cycle read latency.
   initial mem_rd_data = 24'h0;
   always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

   initial mem_rd_data2 = 24'h0;
   always @(posedge clk) if (mem_rd_en2) mem_rd_data2 <= {8'hFF, mem_addr2[7:0], 8'hFF};

   always @(posedge clk) begin
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_compared++;
      if (act !== exp_v) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
      end
   endtask

   // Monitor: pops the scoreboard on each transfer, checks stall stability, done timing, addresses.
   always @(negedge clk) begin
      if (mon_en) begin
         checkOutput("done_timing", 32'(done), 32'(last_prev));
         last_prev = 1'b0;
         if (stall_prev && exp_q.size() > 0) begin
            checkOutput("stall_valid", 32'(out_valid), 32'd1);
            checkOutput("stall_val", 32'(out_val), 32'(exp_q[0].val));
            checkOutput("stall_last", 32'(out_last), 32'(exp_q[0].last));
         end
         if (out_valid && out_ready) begin
            xfer_cnt++;
            if (exp_q.size() == 0) begin
               n_compared++;
               n_mismatched++;
               $display("[TB] FAIL unexpected_xfer: got val 0x%0h, expected no transfer", out_val);
            end else begin
               mon_e = exp_q.pop_front();
               checkOutput("pixel_val", 32'(out_val), 32'(mon_e.val));
               checkOutput("pixel_last", 32'(out_last), 32'(mon_e.last));
               last_prev = mon_e.last;
            end
         end
         stall_prev = out_valid && !out_ready && !rst;
         if (mem_rd_en) begin
            checkOutput("rd_addr", 32'(mem_addr), 32'(exp_addr));
            exp_addr++;
            rd_cnt++;
         end
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         if (out_valid2) begin
            if (out_val2 != ((xfers2 < NPIX2) ? 8'(xfers2) : 8'hFF)) bad2++;
            if (out_last2 != (xfers2 == NXF2 - 1)) bad2++;
            xfers2++;
         end
         if (done2) done_cnt2++;
         if (active2 && !busy2) busy_low2++;
      end
   end

   // Loads memory, queues expected pixels, pulses start and checks first-read and first-valid latency.
   task automatic applyStimulus(input int kind);
      exp_t ent;
      for (int n = 0; n < NPIX; n++) begin
         if (kind == 0) begin
            mem[n]  = {8'(n), 8'(n + 1), 8'(n + 2)};
            ent.val = 8'(n);
         end else begin
            mem[n]  = mix_w[n];
            ent.val = mix_e[n];
         end
         ent.last = 1'b0;
         exp_q.push_back(ent);
      end
      for (int i = 0; i < FL; i++) begin
         ent.val  = 8'hFF;
         ent.last = (i == FL - 1);
         exp_q.push_back(ent);
      end
      xfer_cnt = 0;
      rd_cnt   = 0;
      exp_addr = 0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      checkOutput("lat_rd_en", 32'(mem_rd_en), 32'd1);
      checkOutput("lat_addr0", 32'(mem_addr), 32'd0);
      checkOutput("lat_busy", 32'(busy), 32'd1);
      @(posedge clk); #1 checkOutput("lat_valid_t2", 32'(out_valid), 32'd0);
      @(posedge clk); #1 checkOutput("lat_valid_t3", 32'(out_valid), 32'd1);
   endtask

   task automatic waitDone(input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #1;
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         n_compared++;
         n_mismatched++;
         $display("[TB] FAIL done_timeout: got no done in %0d cycles, expected one pulse", budget);
      end
   endtask

   task automatic endFrameChecks();
      checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
      checkOutput("xfer_count", 32'(xfer_cnt), 32'(NXFER));
      checkOutput("read_count", 32'(rd_cnt), 32'(NPIX));
      checkOutput("busy_after", 32'(busy), 32'd0);
   endtask

   task automatic checkQuiet();
      checkOutput("quiet_busy", 32'(busy), 32'd0);
      checkOutput("quiet_valid", 32'(out_valid), 32'd0);
      checkOutput("quiet_rd_en", 32'(mem_rd_en), 32'd0);
   endtask

   initial begin
      mix_w = '{24'h100303, 24'h808080, 24'h052030, 24'h400750, 24'h607009, 24'hFFFEFF,
                24'h00FFFF, 24'h7F8081, 24'hC0B0A0, 24'h222221, 24'h010001, 24'hFFFFFF};
      mix_e = '{8'h03, 8'h80, 8'h05, 8'h07, 8'h09, 8'hFE,
                8'h00, 8'h7F, 8'hA0, 8'h21, 8'h00, 8'hFF};
      rst       = 1'b1;
      start     = 1'b0;
      start2    = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_rd_en", 32'(mem_rd_en), 32'd0);
      checkOutput("rst_addr", 32'(mem_addr), 32'd0);
      checkOutput("rst_val", 32'(out_val), 32'd0);
      checkOutput("rst_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_last", 32'(out_last), 32'd0);
      rst    = 1'b0;
      mon_en = 1'b1;

      $display("[TB] ramp frame, ready held high");
      applyStimulus(0);
      waitDone(200);
      endFrameChecks();

      $display("[TB] mixed-channel frame");
      applyStimulus(1);
      waitDone(200);
      endFrameChecks();

      $display("[TB] ramp frame, ready toggling");
      rand_ready = 1'b1;
      applyStimulus(0);
      waitDone(500);
      endFrameChecks();
      rand_ready = 1'b0;
      out_ready  = 1'b1;

      $display("[TB] start held during frame and done cycle");
      applyStimulus(0);
      start = 1'b1;
      waitDone(200);
      @(posedge clk); #1 start = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      checkQuiet();
      endFrameChecks();

      $display("[TB] reset after sixth transfer");
      applyStimulus(0);
      for (int i = 0; i < 100 && xfer_cnt < 6; i++) begin
         @(posedge clk); #1;
      end
      checkOutput("six_xfers", 32'(xfer_cnt >= 6), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_done", 32'(done), 32'd0);
      checkOutput("abort_addr", 32'(mem_addr), 32'd0);
      checkOutput("abort_val", 32'(out_val), 32'd0);
      checkOutput("abort_valid", 32'(out_valid), 32'd0);
      checkOutput("abort_last", 32'(out_last), 32'd0);
      repeat (10) @(posedge clk);
      #1;
      checkQuiet();
      applyStimulus(0);
      waitDone(200);
      endFrameChecks();

      $display("[TB] default-size frame");
      @(posedge clk); #1 start2 = 1'b1;
      @(posedge clk); #1 start2 = 1'b0;
      active2 = 1'b1;
      begin
         bit seen2 = 1'b0;
         for (int i = 0; i < 25000; i++) begin
            @(posedge clk); #1;
            if (done2) begin
               seen2 = 1'b1;
               break;
            end
         end
         active2 = 1'b0;
         checkOutput("big_done_seen", 32'(seen2), 32'd1);
      end
      repeat (5) @(posedge clk);
      #1;
      checkOutput("big_xfers", 32'(xfers2), 32'(NXF2));
      checkOutput("big_bad_pixels", 32'(bad2), 32'd0);
      checkOutput("big_busy_low", 32'(busy_low2), 32'd0);
      checkOutput("big_done_count", 32'(done_cnt2), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
